// File: rtl/cp0_if.sv
// Datapath <-> CP0 bus: MFC0/MTC0 access from ID, interrupt/ERET inputs and the PC redirect back.
interface cp0_if;
  logic        en;
  logic        ir_in;
  logic        ir_en;
  logic [31:0] ret_addr;
  logic        eret;
  logic        we;
  logic [4:0]  addr_w;
  logic [31:0] data_w;
  logic [4:0]  addr_r;
  logic [31:0] data_r;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        irq_taken;

  modport master (
    output en, ir_in, ir_en, ret_addr, eret, we, addr_w, data_w, addr_r,
    input  data_r, jump_en, jump_addr, irq_taken
  );

  modport slave (
    input  en, ir_in, ir_en, ret_addr, eret, we, addr_w, data_w, addr_r,
    output data_r, jump_en, jump_addr, irq_taken
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the 5-stage MIPS pipeline: Status/Cause/EPC/Count/Compare,
// external + timer interrupt detection, ERET, and PC redirect generation.
module cp0_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_000C
) (
  input  logic clk,
  input  logic rst,
  cp0_if.slave bus
);
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  logic        ir_q, ir_d;
  logic        ip_ext_q, ip_ext_d;
  logic        ip_tmr_q, ip_tmr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] epc_q, epc_d;
  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [7:0]  im_q, im_d;

  logic        take;
  logic        eret_act;
  logic        wr_count, wr_compare, wr_status, wr_epc;
  logic [31:0] status_word, cause_word;

  assign status_word = {16'h0, im_q, 6'h0, exl_q, ie_q};
  assign cause_word  = {16'h0, ip_tmr_q, 4'h0, ip_ext_q, 10'h0};

  // IM bit 2 gates IP2 (external, Cause bit 10); IM bit 7 gates IP7 (timer, Cause bit 15).
  assign take = bus.en & bus.ir_en & ~bus.eret & ie_q & ~exl_q &
                ((ip_ext_q & im_q[2]) | (ip_tmr_q & im_q[7]));
  assign eret_act = bus.en & bus.eret;

  assign wr_count   = bus.en & bus.we & (bus.addr_w == REG_COUNT);
  assign wr_compare = bus.en & bus.we & (bus.addr_w == REG_COMPARE);
  assign wr_status  = bus.en & bus.we & (bus.addr_w == REG_STATUS);
  assign wr_epc     = bus.en & bus.we & (bus.addr_w == REG_EPC);

  always_comb begin
    ir_d      = bus.ir_in;
    ip_ext_d  = ip_ext_q | (bus.ir_in & ~ir_q);
    ip_tmr_d  = ip_tmr_q | (count_q == compare_q);
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    epc_d     = epc_q;
    ie_d      = ie_q;
    exl_d     = exl_q;
    im_d      = im_q;

    if (take) ip_ext_d = 1'b0;
    if (wr_count) count_d = bus.data_w;
    if (wr_compare) begin
      compare_d = bus.data_w;
      ip_tmr_d  = 1'b0;
    end
    if (wr_status) begin
      ie_d  = bus.data_w[0];
      exl_d = bus.data_w[1];
      im_d  = bus.data_w[15:8];
    end
    if (wr_epc) epc_d = bus.data_w;
    // Hardware interrupt entry overrides a same-cycle software write of EPC/EXL.
    if (take) begin
      epc_d = bus.ret_addr;
      exl_d = 1'b1;
    end else if (eret_act) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q      <= 1'b0;
      ip_ext_q  <= 1'b0;
      ip_tmr_q  <= 1'b0;
      count_q   <= 32'h0;
      compare_q <= 32'h0;
      epc_q     <= 32'h0;
      ie_q      <= 1'b0;
      exl_q     <= 1'b0;
      im_q      <= 8'h0;
    end else begin
      ir_q      <= ir_d;
      ip_ext_q  <= ip_ext_d;
      ip_tmr_q  <= ip_tmr_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      epc_q     <= epc_d;
      ie_q      <= ie_d;
      exl_q     <= exl_d;
      im_q      <= im_d;
    end
  end

  always_comb begin
    bus.data_r    = 32'h0;
    bus.jump_en   = 1'b1;
    bus.jump_addr = epc_q;
    bus.irq_taken = 1'b0;
    if (rst) begin
      bus.jump_addr = 32'h0;
    end else begin
      case (bus.addr_r)
        REG_COUNT:   bus.data_r = count_q;
        REG_COMPARE: bus.data_r = compare_q;
        REG_STATUS:  bus.data_r = status_word;
        REG_CAUSE:   bus.data_r = cause_word;
        REG_EPC:     bus.data_r = epc_q;
        default:     bus.data_r = 32'h0;
      endcase
      if (take) begin
        bus.jump_en   = 1'b0;
        bus.jump_addr = HANDLER_ADDR;
        bus.irq_taken = 1'b1;
      end else if (eret_act) begin
        bus.jump_en = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: architectural model checked every cycle plus literal spot checks.
module tb_cp0_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  cp0_if bus ();

  cp0_unit #(.HANDLER_ADDR(32'h0000_000C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Architectural state of CP0 as software sees it.
  logic [31:0] m_count = 0, m_compare = 0, m_epc = 0, m_status = 0;
  logic        m_ext = 0, m_tmr = 0, m_ir_prev = 0;

  function automatic logic m_take();
    logic want;
    want = (m_ext && m_status[10]) || (m_tmr && m_status[15]);
    return bus.en && bus.ir_en && !bus.eret && m_status[0] && !m_status[1] && want;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return (32'(m_tmr) << 15) | (32'(m_ext) << 10);
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic tk, wr;
    logic [31:0] st;
    if (rst) begin
      m_count <= 0; m_compare <= 0; m_epc <= 0; m_status <= 0;
      m_ext <= 0; m_tmr <= 0; m_ir_prev <= 0;
    end else begin
      tk = m_take();
      wr = bus.en && bus.we;
      m_ir_prev <= bus.ir_in;
      m_ext <= tk ? 1'b0 : (m_ext || (bus.ir_in && !m_ir_prev));
      m_tmr <= (wr && bus.addr_w == 5'd11) ? 1'b0 : (m_tmr || (m_count == m_compare));
      m_count <= (wr && bus.addr_w == 5'd9) ? bus.data_w : m_count + 1;
      if (wr && bus.addr_w == 5'd11) m_compare <= bus.data_w;
      st = (wr && bus.addr_w == 5'd12) ? (bus.data_w & 32'h0000_FF03) : m_status;
      if (tk) st[1] = 1'b1;
      else if (bus.en && bus.eret) st[1] = 1'b0;
      m_status <= st;
      m_epc <= tk ? bus.ret_addr : ((wr && bus.addr_w == 5'd14) ? bus.data_w : m_epc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the model, on the falling edge.
  always @(negedge clk) begin
    logic [31:0] e_addr, e_data;
    logic e_jen, e_irq, tk;
    tk = !rst && m_take();
    e_irq  = tk;
    e_jen  = rst ? 1'b1 : !(tk || (bus.en && bus.eret));
    e_addr = rst ? 32'h0 : (tk ? 32'h0000_000C : m_epc);
    e_data = rst ? 32'h0 : m_read(bus.addr_r);
    chk("mdl_irq_taken", 32'(bus.irq_taken), 32'(e_irq));
    chk("mdl_jump_en", 32'(bus.jump_en), 32'(e_jen));
    chk("mdl_jump_addr", bus.jump_addr, e_addr);
    chk("mdl_data_r", bus.data_r, e_data);
    $display("cyc t=%0t rst=%0b en=%0b ir=%0b eret=%0b we=%0b aw=%0d dw=%h ar=%0d dr=%h jen=%0b ja=%h irq=%0b",
             $time, rst, bus.en, bus.ir_in, bus.eret, bus.we, bus.addr_w, bus.data_w,
             bus.addr_r, bus.data_r, bus.jump_en, bus.jump_addr, bus.irq_taken);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    rst = 1'b0; bus.en = 1'b1; bus.ir_en = 1'b1; bus.ir_in = 1'b0;
    bus.eret = 1'b0; bus.we = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.addr_w = a; bus.data_w = d;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b1; bus.ir_en = 1'b1; bus.ir_in = 1'b0; bus.ret_addr = 0;
    bus.eret = 1'b0; bus.we = 1'b0; bus.addr_w = 0; bus.data_w = 0; bus.addr_r = 5'd12;
    repeat (3) @(posedge clk);
    #1; settle();
    chk("rst_data_r", bus.data_r, 32'h0);
    chk("rst_jump_en", 32'(bus.jump_en), 32'h1);
    chk("rst_jump_addr", bus.jump_addr, 32'h0);
    chk("rst_irq", 32'(bus.irq_taken), 32'h0);

    cyc(); mtc0(5'd11, 32'hFFFF_0000);
    bus.addr_r = 5'd12; settle(); chk("init_status", bus.data_r, 32'h0);
    bus.addr_r = 5'd13; settle(); chk("init_cause", bus.data_r, 32'h0);
    bus.addr_r = 5'd14; settle(); chk("init_epc", bus.data_r, 32'h0);
    cyc(); mtc0(5'd12, 32'h0000_0401);
    cyc(); bus.addr_r = 5'd12; bus.ir_in = 1'b1; bus.ret_addr = 32'h40; settle();
    chk("status_wr", bus.data_r, 32'h0000_0401);
    chk("no_take_edge_cyc", 32'(bus.irq_taken), 32'h0);
    cyc(); settle();
    chk("ext_take_irq", 32'(bus.irq_taken), 32'h1);
    chk("ext_take_jen", 32'(bus.jump_en), 32'h0);
    chk("ext_take_ja", bus.jump_addr, 32'h0000_000C);
    cyc(); bus.ir_in = 1'b1;
    bus.addr_r = 5'd12; settle(); chk("exl_set", bus.data_r, 32'h0000_0403);
    bus.addr_r = 5'd14; settle(); chk("epc_saved", bus.data_r, 32'h40);
    bus.addr_r = 5'd13; settle(); chk("ip2_cleared", bus.data_r, 32'h0);
    chk("no_take_in_handler", 32'(bus.irq_taken), 32'h0);
    cyc(); settle();
    chk("ip2_pending", bus.data_r, 32'h0000_0400);
    chk("exl_blocks", 32'(bus.jump_en), 32'h1);
    cyc(); bus.eret = 1'b1; settle();
    chk("eret_jen", 32'(bus.jump_en), 32'h0);
    chk("eret_ja", bus.jump_addr, 32'h40);
    chk("eret_irq", 32'(bus.irq_taken), 32'h0);
    cyc(); bus.ret_addr = 32'h44; bus.addr_r = 5'd12; settle();
    chk("exl_cleared", bus.data_r, 32'h0000_0401);
    chk("pending_taken", 32'(bus.irq_taken), 32'h1);
    cyc(); bus.eret = 1'b1; settle(); chk("eret2_ja", bus.jump_addr, 32'h44);

    cyc(); mtc0(5'd12, 32'h0000_8001);
    cyc(); mtc0(5'd9, 32'd100);
    cyc(); mtc0(5'd11, 32'd105); bus.ret_addr = 32'h50; bus.addr_r = 5'd9; settle();
    chk("count_wr", bus.data_r, 32'd100);
    for (int k = 1; k <= 5; k++) begin
      cyc(); settle(); chk("tmr_wait", 32'(bus.irq_taken), 32'h0);
    end
    chk("count_at_match", bus.data_r, 32'd105);
    cyc(); settle();
    chk("tmr_take", 32'(bus.irq_taken), 32'h1);
    chk("tmr_take_ja", bus.jump_addr, 32'h0000_000C);
    cyc(); mtc0(5'd11, 32'd1000); bus.addr_r = 5'd13; settle();
    chk("ip7_kept", bus.data_r, 32'h0000_8000);
    cyc(); bus.eret = 1'b1; settle();
    chk("ip7_cleared", bus.data_r, 32'h0);
    chk("tmr_eret_ja", bus.jump_addr, 32'h50);

    cyc(); mtc0(5'd12, 32'h0000_0401);
    cyc(); bus.ir_in = 1'b1; bus.ir_en = 1'b0;
    cyc(); bus.ir_en = 1'b0; mtc0(5'd9, 32'd500); settle();
    chk("ir_en0_jen", 32'(bus.jump_en), 32'h1);
    chk("ir_en0_irq", 32'(bus.irq_taken), 32'h0);
    cyc(); bus.en = 1'b0; bus.addr_r = 5'd9; settle();
    chk("stall_jen", 32'(bus.jump_en), 32'h1);
    chk("stall_count0", bus.data_r, 32'd500);
    cyc(); bus.en = 1'b0; mtc0(5'd9, 32'd7); settle();
    chk("stall_count1", bus.data_r, 32'd501);
    chk("stall_irq", 32'(bus.irq_taken), 32'h0);
    cyc(); bus.ret_addr = 32'h60; settle();
    chk("stall_wr_ignored", bus.data_r, 32'd502);
    chk("unstall_take", 32'(bus.irq_taken), 32'h1);
    cyc(); bus.eret = 1'b1; settle(); chk("eret3_ja", bus.jump_addr, 32'h60);

    cyc(); bus.ir_in = 1'b1;
    cyc(); bus.ret_addr = 32'h80; mtc0(5'd14, 32'h99); settle();
    chk("take_with_mtc0", 32'(bus.irq_taken), 32'h1);
    cyc(); bus.eret = 1'b1;
    bus.addr_r = 5'd14; settle(); chk("epc_hw_wins", bus.data_r, 32'h80);
    bus.addr_r = 5'd12; settle(); chk("exl_after_race", bus.data_r, 32'h0000_0403);
    cyc(); bus.ir_in = 1'b1;
    cyc(); bus.eret = 1'b1; settle();
    chk("eret_blocks_irq", 32'(bus.irq_taken), 32'h0);
    chk("eret_blocks_ja", bus.jump_addr, 32'h80);
    cyc(); bus.ret_addr = 32'h90; settle();
    chk("post_eret_take", 32'(bus.irq_taken), 32'h1);

    cyc(); rst = 1'b1; bus.addr_r = 5'd12; settle();
    chk("midrst_data_r", bus.data_r, 32'h0);
    chk("midrst_ja", bus.jump_addr, 32'h0);
    cyc(); bus.ir_in = 1'b1; settle(); chk("midrst_status", bus.data_r, 32'h0);
    cyc(); bus.addr_r = 5'd13; settle();
    chk("midrst_no_take", 32'(bus.irq_taken), 32'h0);
    chk("midrst_cause", bus.data_r, 32'h0000_8400);
    cyc(); mtc0(5'd9, 32'hFFFF_FFFF);
    cyc(); bus.addr_r = 5'd9; settle(); chk("count_max", bus.data_r, 32'hFFFF_FFFF);
    cyc(); settle(); chk("count_wrap", bus.data_r, 32'h0);
    cyc(); bus.addr_r = 5'd3; mtc0(5'd3, 32'h1234_5678);
    cyc(); settle(); chk("unmapped_read", bus.data_r, 32'h0);
    cyc(); @(posedge clk); #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
